fifo_block_accumulator: RTL and testbench

Downstream consumer of the `fifo` block in the DSP datapath. It pops samples from the FIFO whenever the FIFO is non-empty and sums each group of `BLOCK_LEN` consecutive samples. Each completed block sum is presented on a valid/ready output to the next stage, either a Wishbone register or a further DSP stage. Backpressure on the output stalls FIFO reads, so no sample is ever dropped.

---
 rtl/fifo_block_accumulator.sv | 92 +++++++++
 tb/tb_fifo_block_accumulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_block_accumulator.sv
// Pops samples from an upstream FIFO and sums each group of BLOCK_LEN of them,
// presenting every completed block sum on a valid/ready output.
module fifo_block_accumulator #(
    parameter int DW        = 32,
    parameter int BLOCK_LEN = 16,
    parameter int SIGNED    = 1,
    localparam int SW       = DW + $clog2(BLOCK_LEN),
    localparam int CW       = $clog2(BLOCK_LEN) + 1
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          enable,
    input  logic          clear,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_pop,
    output logic [SW-1:0] sum_data,
    output logic          sum_valid,
    input  logic          sum_ready,
    output logic [CW-1:0] sample_count,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, FETCH, SETTLE, EMIT} state_t;

    state_t        state;
    logic [SW-1:0] acc;
    logic [CW-1:0] count;
    logic [SW-1:0] sample_ext;

    always_comb begin
        sample_ext = '0;
        if (SIGNED != 0) sample_ext = SW'($signed(fifo_data));
        else             sample_ext = SW'(fifo_data);
    end

    // Pop is combinational so the FIFO advances on the same edge that captures the head word.
    assign fifo_pop     = (state == FETCH) && enable && !fifo_empty && !clear;
    assign busy         = (state != IDLE);
    assign sample_count = count;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sum_data  <= '0;
            sum_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sum_data  <= '0;
            sum_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state <= FETCH;
                end
                FETCH: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!fifo_empty) begin
                        acc   <= acc + sample_ext;
                        count <= count + CW'(1);
                        state <= SETTLE;
                    end
                end
                // Dead cycle lets the FIFO pointer and empty flag catch up with the pop.
                SETTLE: begin
                    if (count == CW'(BLOCK_LEN)) begin
                        sum_data  <= acc;
                        sum_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        state <= FETCH;
                    end
                end
                EMIT: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        state     <= enable ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_block_accumulator.sv
// Directed bench: a queue-based FIFO model feeds three accumulator variants
// (32-bit unsigned, 32-bit signed, 8-bit unsigned) with identical control.
module tb_fifo_block_accumulator;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        sum_ready = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        push_en = 1'b0;
    logic [31:0] push_data = '0;

    logic        fifo_pop, sum_valid, busy;
    logic [33:0] sum_data;
    logic [2:0]  sample_count;
    logic        s_pop, s_valid, s_busy;
    logic [33:0] s_sum;
    logic [2:0]  s_cnt;
    logic        b_pop, b_valid, b_busy;
    logic [9:0]  b_sum;
    logic [2:0]  b_cnt;

    logic [31:0] q[$];
    int          pops = 0;
    int          bad_pops = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 wb_clk = ~wb_clk;

    fifo_block_accumulator #(.DW(32), .BLOCK_LEN(4), .SIGNED(0)) u_main (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .clear(clear),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .sum_data(sum_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .sample_count(sample_count), .busy(busy));

    fifo_block_accumulator #(.DW(32), .BLOCK_LEN(4), .SIGNED(1)) u_sgn (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .clear(clear),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(s_pop),
        .sum_data(s_sum), .sum_valid(s_valid), .sum_ready(sum_ready),
        .sample_count(s_cnt), .busy(s_busy));

    fifo_block_accumulator #(.DW(8), .BLOCK_LEN(4), .SIGNED(0)) u_b8 (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .clear(clear),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data[7:0]), .fifo_pop(b_pop),
        .sum_data(b_sum), .sum_valid(b_valid), .sum_ready(sum_ready),
        .sample_count(b_cnt), .busy(b_busy));

    // FIFO model: registered empty/head, popped by the 32-bit unsigned instance.
    always @(posedge wb_clk) begin
        if (fifo_pop) begin
            pops++;
            if (fifo_empty || q.size() == 0) bad_pops++;
            if (q.size() != 0) q.delete(0);
        end
        if (push_en) q.push_back(push_data);
        fifo_empty <= (q.size() == 0);
        fifo_data  <= (q.size() != 0) ? q[0] : 32'h0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic push(input logic [31:0] v);
        push_en   = 1'b1;
        push_data = v;
        @(negedge wb_clk);
        push_en   = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge wb_clk);
            n++;
        end while (!sum_valid && n < 100);
        chk(tag, 64'(sum_valid), 64'd1);
    endtask

    initial begin
        int first, nvld, p0;
        logic [33:0] s_main;

        // Reset state
        tick(1);
        chk("rst_pop", 64'(fifo_pop), 64'd0);
        chk("rst_sum", 64'(sum_data), 64'd0);
        chk("rst_vld", 64'(sum_valid), 64'd0);
        chk("rst_cnt", 64'(sample_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick(2);
        wb_rst = 1'b1;
        tick(2);

        // Basic block 1,2,3,4 with exact latency
        p0 = pops;
        push(1); push(2); push(3); push(4);
        enable = 1'b1;
        first = 0; nvld = 0; s_main = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge wb_clk);
            if (sum_valid) begin
                if (first == 0) first = i;
                nvld++;
                s_main = sum_data;
                chk("emit_cnt", 64'(sample_count), 64'd4);
            end
        end
        chk("lat_first", 64'(first), 64'd9);
        chk("lat_width", 64'(nvld), 64'd1);
        chk("basic_sum", 64'(s_main), 64'd10);
        chk("basic_pops", 64'(pops - p0), 64'd4);
        chk("basic_qempty", 64'(q.size()), 64'd0);
        enable = 1'b0;
        tick(3);

        // All-ones samples: sign extension and 8-bit width extreme
        push(32'hFFFF_FFFF); push(32'hFFFF_FFFF); push(32'hFFFF_FFFF); push(32'hFFFF_FFFF);
        enable = 1'b1;
        wait_valid("ones_vld");
        chk("ones_u32", 64'(sum_data), 64'h3_FFFF_FFFC);
        chk("ones_s32", 64'(s_sum), 64'h3_FFFF_FFFC);
        chk("ones_b8", 64'(b_sum), 64'h3FC);
        enable = 1'b0;
        tick(3);

        // Mixed sign: only the signed variant extends the MSB
        push(32'h8000_0000); push(1); push(1); push(1);
        enable = 1'b1;
        wait_valid("mix_vld");
        chk("mix_u32", 64'(sum_data), 64'h0_8000_0003);
        chk("mix_s32", 64'(s_sum), 64'h3_8000_0003);
        chk("mix_b8", 64'(b_sum), 64'h003);
        enable = 1'b0;
        tick(3);

        // Backpressure: 8 samples of 5, ready held low
        sum_ready = 1'b0;
        p0 = pops;
        for (int i = 0; i < 8; i++) push(5);
        enable = 1'b1;
        wait_valid("bp_vld1");
        chk("bp_sum1", 64'(sum_data), 64'd20);
        tick(10);
        chk("bp_hold_vld", 64'(sum_valid), 64'd1);
        chk("bp_hold_sum", 64'(sum_data), 64'd20);
        chk("bp_qsize", 64'(q.size()), 64'd4);
        chk("bp_pops", 64'(pops - p0), 64'd4);
        chk("bp_cnt", 64'(sample_count), 64'd4);
        sum_ready = 1'b1;
        wait_valid("bp_vld2");
        chk("bp_sum2", 64'(sum_data), 64'd20);
        chk("bp_pops2", 64'(pops - p0), 64'd8);
        enable = 1'b0;
        tick(3);

        // Empty gap mid-block
        p0 = pops;
        enable = 1'b1;
        push(3); push(4);
        tick(10);
        chk("gap_cnt", 64'(sample_count), 64'd2);
        chk("gap_busy", 64'(busy), 64'd1);
        chk("gap_pops_mid", 64'(pops - p0), 64'd2);
        push(5); push(6);
        wait_valid("gap_vld");
        chk("gap_sum", 64'(sum_data), 64'd18);
        chk("gap_pops", 64'(pops - p0), 64'd4);
        chk("no_empty_pop", 64'(bad_pops), 64'd0);
        enable = 1'b0;
        tick(3);

        // Async reset mid-block
        enable = 1'b1;
        push(1); push(1);
        tick(6);
        chk("prerst_cnt", 64'(sample_count), 64'd2);
        wb_rst = 1'b0;
        #1;
        chk("arst_cnt", 64'(sample_count), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_vld", 64'(sum_valid), 64'd0);
        chk("arst_sum", 64'(sum_data), 64'd0);
        enable = 1'b0;
        @(negedge wb_clk);
        wb_rst = 1'b1;
        tick(2);

        // Clear during EMIT discards the pending sum
        sum_ready = 1'b0;
        enable = 1'b1;
        push(7); push(7); push(7); push(7);
        wait_valid("clr_vld");
        chk("clr_presum", 64'(sum_data), 64'd28);
        clear = 1'b1;
        @(negedge wb_clk);
        chk("clr_vld0", 64'(sum_valid), 64'd0);
        chk("clr_sum0", 64'(sum_data), 64'd0);
        chk("clr_cnt0", 64'(sample_count), 64'd0);
        chk("clr_busy0", 64'(busy), 64'd0);
        clear = 1'b0;
        sum_ready = 1'b1;
        push(1); push(1); push(1); push(1);
        wait_valid("post_clr_vld");
        chk("post_clr_sum", 64'(sum_data), 64'd4);
        enable = 1'b0;
        tick(3);

        // Enable dropped after two pops
        p0 = pops;
        push(10); push(20); push(30); push(40);
        enable = 1'b1;
        tick(4);
        chk("en_pops2", 64'(pops - p0), 64'd2);
        enable = 1'b0;
        tick(6);
        chk("en_off_pops", 64'(pops - p0), 64'd2);
        chk("en_off_q", 64'(q.size()), 64'd2);
        chk("en_off_cnt", 64'(sample_count), 64'd2);
        chk("en_off_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        wait_valid("en_vld");
        chk("en_sum", 64'(sum_data), 64'd100);
        chk("en_pops4", 64'(pops - p0), 64'd4);
        enable = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
